// File: rtl/shifter_2.sv
// Fixed left shift by SHAMT: Output = Input << SHAMT, registered (MIPS branch/jump byte offset).
// Latency: exactly 1 clk; the register loads on every rising edge, with no enable.
// Backpressure: none. There is no stall or ready; a new Input is accepted every cycle.
//
// Ports:
//   clk       core clock, rising-edge active
//   rst       asynchronous active-high reset; clears Output/out_valid (and ovf) at once
//   Input     WIDTH-bit word to shift
//   Output    registered Input << SHAMT (logical shift; low SHAMT bits are always 0)
//   out_valid 1 from the first edge after reset release until the next reset
//   ovf       (only with `define SHIFTER_2_OVF_EN) signed-offset overflow, registered with Output
//
// Optional build macro: SHIFTER_2_OVF_EN adds the ovf output and its logic.

module shifter_2 #(
    parameter int WIDTH = 32,
    parameter int SHAMT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Input,
    output logic [WIDTH-1:0] Output,
    output logic             out_valid
`ifdef SHIFTER_2_OVF_EN
    ,
    output logic             ovf
`endif
);

    // An illegal shift amount would produce empty or reversed slices, so
    // stop elaboration instead.
    generate
        if (SHAMT < 1 || SHAMT > WIDTH - 1) begin : g_bad_shamt
            $error("shifter_2: SHAMT must be in 1..WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             vld_q;

    // The shift operator discards the top SHAMT bits and zero-fills the
    // bottom bits. Each remaining bit (including X/Z in simulation) moves
    // to its shifted position unchanged.
    always_comb begin
        out_d = Input << SHAMT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= 1'b1;
        end
    end

    assign Output    = out_q;
    assign out_valid = vld_q;

`ifdef SHIFTER_2_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Treat the result as a signed offset. The shift is lossless only when
    // every discarded bit equals the new sign bit Input[WIDTH-1-SHAMT].
    always_comb begin
        ovf_d = (Input[WIDTH-1:WIDTH-SHAMT] != {SHAMT{Input[WIDTH-1-SHAMT]}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_shifter_2.sv
// Directed bench for shifter_2: the default 32/2 instance plus a 16/1 instance.
// Inputs change on the falling edge and are checked 1 time unit after the rising edge.
// Expected values are hand-computed constants.

module tb_shifter_2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        dvld;
    logic [15:0] din16 = '0;
    logic [15:0] dout16;
    logic        dvld16;
`ifdef SHIFTER_2_OVF_EN
    logic        dovf;
    logic        dovf16;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shifter_2 #(.WIDTH(32), .SHAMT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .Input     (din),
        .Output    (dout),
        .out_valid (dvld)
`ifdef SHIFTER_2_OVF_EN
        ,
        .ovf       (dovf)
`endif
    );

    shifter_2 #(.WIDTH(16), .SHAMT(1)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .Input     (din16),
        .Output    (dout16),
        .out_valid (dvld16)
`ifdef SHIFTER_2_OVF_EN
        ,
        .ovf       (dovf16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply v before the next rising edge, then check the registered result.
    task automatic step(input string tag, input logic [31:0] v, input logic [31:0] exp);
        @(negedge clk);
        din = v;
        @(posedge clk);
        #1;
        check(tag, dout, exp);
        check({tag, "_vld"}, {31'b0, dvld}, 32'd1);
    endtask

    logic [31:0] stream_in  [4] = '{32'h1, 32'h2, 32'h3, 32'h7FFF_FFFF};
    logic [31:0] stream_exp [4] = '{32'h4, 32'h8, 32'hC, 32'hFFFF_FFFC};

    initial begin
        // Reset is high from time 0, so both outputs are already cleared.
        #1;
        check("rst_out", dout, 32'h0);
        check("rst_vld", {31'b0, dvld}, 32'd0);
        check("rst_out16", {16'b0, dout16}, 32'h0);

        // Release reset mid-cycle. The first edge loads Input with no dead cycle.
        @(negedge clk);
        rst = 1'b0;
        din = 32'h4;
        @(posedge clk);
        #1;
        check("first_edge_out", dout, 32'h10);
        check("first_edge_vld", {31'b0, dvld}, 32'd1);

        // Assert reset asynchronously mid-cycle; check before any clock edge.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out", dout, 32'h0);
        check("async_rst_vld", {31'b0, dvld}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_out", dout, 32'h0);
        check("rst_hold_vld", {31'b0, dvld}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        step("basic_1", 32'h0000_0001, 32'h0000_0004);
        step("basic_0", 32'h0000_0000, 32'h0000_0000);
        step("neg_1", 32'hFFFF_FFFF, 32'hFFFF_FFFC);
`ifdef SHIFTER_2_OVF_EN
        check("ovf_neg_1", {31'b0, dovf}, 32'd0);
`endif
        step("neg_8000", 32'hFFFF_8000, 32'hFFFE_0000);
        step("discard_c", 32'hC000_0001, 32'h0000_0004);
        step("discard_4", 32'h4000_0000, 32'h0000_0000);
`ifdef SHIFTER_2_OVF_EN
        check("ovf_4000", {31'b0, dovf}, 32'd1);
`endif
        step("bound_3fff", 32'h3FFF_FFFF, 32'hFFFF_FFFC);
`ifdef SHIFTER_2_OVF_EN
        check("ovf_3fff", {31'b0, dovf}, 32'd1);
`endif
        step("neg_e000", 32'hE000_0000, 32'h8000_0000);
`ifdef SHIFTER_2_OVF_EN
        check("ovf_e000", {31'b0, dovf}, 32'd0);
`endif

        // No combinational path: changing Input mid-cycle leaves Output alone.
        @(negedge clk);
        din = 32'h1234_5678;
        #1;
        check("stable_mid", dout, 32'h8000_0000);

        // Back-to-back streaming with one new value every cycle.
        for (int i = 0; i < 4; i++) begin
            step($sformatf("stream_%0d", i), stream_in[i], stream_exp[i]);
        end

        // The 16-bit, shift-by-1 instance.
        @(negedge clk);
        din16 = 16'h8001;
        @(posedge clk);
        #1;
        check("w16_8001", {16'b0, dout16}, 32'h0002);
        check("w16_vld", {31'b0, dvld16}, 32'd1);
`ifdef SHIFTER_2_OVF_EN
        check("w16_ovf", {31'b0, dovf16}, 32'd1);
`endif
        @(negedge clk);
        din16 = 16'h4000;
        @(posedge clk);
        #1;
        check("w16_4000", {16'b0, dout16}, 32'h8000);

        // A reset during streaming drops the value in flight.
        @(negedge clk);
        din = 32'h0000_0005;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("inflight_lost", dout, 32'h0);
`ifdef SHIFTER_2_OVF_EN
        check("ovf_rst", {31'b0, dovf}, 32'd0);
`endif
        rst = 1'b0;
        step("after_rst", 32'h0000_0005, 32'h0000_0014);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
